gift_inv_sbox_layer_masked: RTL

- Two-share masked inverse GIFT S-box layer, the decryption-side counterpart of the team's masked forward GIFT S-box.
- Takes a 64-bit GIFT state as two Boolean shares and runs its 16 nibbles serially through one registered, masked inverse S-box core.
- Returns the 64-bit result as two shares, with a start/busy/done handshake.
- Sits in the serial GIFT decryption datapath between the inverse permutation and the round-key XOR.

---
 rtl/gift_inv_sbox_layer_masked.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/gift_inv_sbox_layer_masked.sv
// Two-share masked inverse GIFT S-box layer.
// The 16 nibbles of a shared 64-bit state pass one at a time through a
// two-stage masked inverse S-box core. The core computes the algebraic normal
// form of InvS directly on the shares. Every registered term takes exactly one
// share of each input bit it depends on, and no fresh randomness is used.
module gift_inv_sbox_layer_masked #(
    parameter int NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   state_s0,
    input  logic [4*NIBBLES-1:0]   state_s1,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result_s0,
    output logic [4*NIBBLES-1:0]   result_s1
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    // Nibble i of this constant is InvS(i).
    localparam logic [63:0] INV_SBOX = 64'h5F93A17EB4C2680D;

    // ANF coefficients of InvS: bit (16*b + m) is the coefficient of the
    // monomial prod_{j in m} x_j in output bit b (Moebius transform of the table).
    function automatic logic [63:0] anf_table();
        logic [63:0] t;
        t = '0;
        for (int b = 0; b < 4; b++)
            for (int m = 0; m < 16; m++)
                for (int x = 0; x < 16; x++)
                    if ((x & ~m) == 0)
                        t[b*16+m] = t[b*16+m] ^ INV_SBOX[x*4+b];
        return t;
    endfunction

    localparam logic [63:0] ANF = anf_table();

    // Cross product of the variables in m, where a selects share 1 (bit set)
    // or share 0 (bit clear) of each variable. Zero when a is not a subset of m.
    function automatic logic xprod(input logic [3:0] sh0, input logic [3:0] sh1,
                                   input logic [3:0] m,   input logic [3:0] a);
        logic p;
        p = 1'b1;
        for (int j = 0; j < 4; j++)
            if (m[j])
                p = p & (a[j] ? sh1[j] : sh0[j]);
        if ((a & ~m) != 4'b0000)
            p = 1'b0;
        return p;
    endfunction

    // Output share that collects a cross term: the share used by its lowest
    // variable. Pure share-0 terms go to share 0, pure share-1 terms to share 1.
    function automatic logic out_share(input logic [3:0] m, input logic [3:0] a);
        logic g;
        g = 1'b0;
        for (int j = 3; j >= 0; j--)
            if (m[j])
                g = a[j];
        return g;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;

    fsm_t          fsm;
    logic [CW-1:0] cnt;
    logic          dcnt;
    logic [W-1:0]  s0_q;
    logic [W-1:0]  s1_q;
    logic          accept;

    logic          vld_p0;
    logic [3:0]    in0_p0;
    logic [3:0]    in1_p0;

    logic          lo_p1 [16];
    logic          hi_p1 [16];
    logic          vld_p1;
    logic [CW-1:0] idx_p1;

    logic          q_p2 [256];
    logic          vld_p2;
    logic [CW-1:0] idx_p2;

    logic [3:0]    out0;
    logic [3:0]    out1;

    // The completion cycle also counts as idle for a new request, so a start
    // in the cycle where done is high is accepted.
    assign accept = start && ((fsm == IDLE) || (fsm == DONE));

    // ---- stage 0: issue nibble cnt from the captured shares
    assign vld_p0 = (fsm == RUN);
    assign in0_p0 = s0_q[{cnt, 2'b00} +: 4];
    assign in1_p0 = s1_q[{cnt, 2'b00} +: 4];

    // Control FSM with registered busy/done; busy rises on the first issue edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm  <= IDLE;
            cnt  <= '0;
            dcnt <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        fsm <= RUN;
                        cnt <= '0;
                    end else begin
                        fsm <= IDLE;
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    if (cnt == LAST) begin
                        fsm  <= DRAIN;
                        dcnt <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt) begin
                        fsm  <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        dcnt <= 1'b1;
                        busy <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Capture both input shares on an accepted start; they are never combined.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else if (accept) begin
            s0_q <= state_s0;
            s1_q <= state_s1;
        end
    end

    // ---- stage 1: share-wise cross products of the low pair and high pair of bits
    // Entry {mh, ah}: monomial mh over the pair, share choice ah per variable.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            for (int i = 0; i < 16; i++) begin
                lo_p1[i] <= 1'b0;
                hi_p1[i] <= 1'b0;
            end
        end else begin
            vld_p1 <= vld_p0;
            idx_p1 <= cnt;
            for (int i = 0; i < 16; i++) begin
                lo_p1[i] <= xprod({2'b00, in0_p0[1:0]}, {2'b00, in1_p0[1:0]},
                                  {2'b00, i[3:2]}, {2'b00, i[1:0]});
                hi_p1[i] <= xprod({2'b00, in0_p0[3:2]}, {2'b00, in1_p0[3:2]},
                                  {2'b00, i[3:2]}, {2'b00, i[1:0]});
            end
        end
    end

    // ---- stage 2: full 4-variable cross terms, entry {m, a}
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            idx_p2 <= '0;
            for (int k = 0; k < 256; k++)
                q_p2[k] <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            idx_p2 <= idx_p1;
            for (int k = 0; k < 256; k++)
                q_p2[k] <= lo_p1[{k[5:4], k[1:0]}] & hi_p1[{k[7:6], k[3:2]}];
        end
    end

    // XOR compression of the stage-2 terms into the two output shares.
    always_comb begin
        out0 = 4'b0000;
        out1 = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 256; k++) begin
                if (ANF[{b[1:0], k[7:4]}] && ((k[3:0] & ~k[7:4]) == 4'b0000)) begin
                    if (out_share(k[7:4], k[3:0]))
                        out1[b] = out1[b] ^ q_p2[k];
                    else
                        out0[b] = out0[b] ^ q_p2[k];
                end
            end
        end
    end

    // Write each finished nibble back into the result shares; others hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_s0 <= '0;
            result_s1 <= '0;
        end else if (vld_p2) begin
            result_s0[{idx_p2, 2'b00} +: 4] <= out0;
            result_s1[{idx_p2, 2'b00} +: 4] <= out1;
        end
    end

endmodule
